// File: rtl/hdmi_video_sequencer.sv
// Raster and pixel-fetch sequencer for the HDMI TMDS path.
// Requests lead the delayed sync/active outputs by LEAD cycles.
module hdmi_video_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = 2
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic        en,
  output logic        busy,
  output logic        req_valid,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t      state;
  logic [11:0] h;
  logic [11:0] v;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;

  logic run;
  logic last;
  logic vis;
  logic hs;
  logic vs;
  logic fs;

  // Index LEAD of each pipe is the output stage.
  logic [LEAD:0] hs_p;
  logic [LEAD:0] vs_p;
  logic [LEAD:0] de_p;
  logic [LEAD:0] fs_p;

  assign run  = (state != IDLE);
  assign last = (h == H_LAST) && (v == V_LAST);
  assign vis  = run && (h < H_VIS) && (v < V_VIS);
  assign hs   = run && (h >= HS_BEG) && (h < HS_END);
  assign vs   = run && (v >= VS_BEG) && (v < VS_END);
  assign fs   = vis && (h == 12'd0) && (v == 12'd0);

  always_comb begin
    h_nxt = h + 12'd1;
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = 12'd0;
      v_nxt = (v == V_LAST) ? 12'd0 : v + 12'd1;
    end
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      h         <= 12'd0;
      v         <= 12'd0;
      req_valid <= 1'b0;
      req_x     <= 12'd0;
      req_y     <= 12'd0;
      hs_p      <= {(LEAD + 1){~HS_POL}};
      vs_p      <= {(LEAD + 1){~VS_POL}};
      de_p      <= '0;
      fs_p      <= '0;
    end else begin
      req_valid <= vis;
      req_x     <= vis ? h : 12'd0;
      req_y     <= vis ? v : 12'd0;
      hs_p      <= {hs_p[LEAD-1:0], hs ? HS_POL : ~HS_POL};
      vs_p      <= {vs_p[LEAD-1:0], vs ? VS_POL : ~VS_POL};
      de_p      <= {de_p[LEAD-1:0], vis};
      fs_p      <= {fs_p[LEAD-1:0], fs};
      unique case (state)
        IDLE: begin
          h <= 12'd0;
          v <= 12'd0;
          if (en) state <= RUN;
        end
        RUN: begin
          h <= h_nxt;
          v <= v_nxt;
          if (!en) state <= last ? IDLE : DRAIN;
        end
        DRAIN: begin
          h <= h_nxt;
          v <= v_nxt;
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = run;
  assign hsync       = hs_p[LEAD];
  assign vsync       = vs_p[LEAD];
  assign active      = de_p[LEAD];
  assign frame_start = fs_p[LEAD];

endmodule

// File: tb/tb_hdmi_video_sequencer.sv
// Bench for hdmi_video_sequencer: small raster against a linear-position
// reference model, default raster against fixed timing points.
module tb_hdmi_video_sequencer;

  localparam int HA  = 8;
  localparam int HT  = 15;
  localparam int HSB = 10;
  localparam int HSE = 13;
  localparam int VA  = 4;
  localparam int VT  = 8;
  localparam int VSB = 5;
  localparam int VSE = 7;
  localparam int TOT = HT * VT;
  localparam int SL  = 3;

  localparam logic [29:0] RST_VEC =
    {1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst;
  logic en_s;
  logic en_d;

  always #5 clk = ~clk;

  logic        s_busy, s_req_valid, s_hsync, s_vsync, s_active, s_frame_start;
  logic [11:0] s_req_x, s_req_y;
  logic        d_busy, d_req_valid, d_hsync, d_vsync, d_active, d_frame_start;
  logic [11:0] d_req_x, d_req_y;

  hdmi_video_sequencer #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(3)
  ) u_s (
    .clk_pixel(clk), .rst(rst), .en(en_s),
    .busy(s_busy), .req_valid(s_req_valid),
    .req_x(s_req_x), .req_y(s_req_y),
    .hsync(s_hsync), .vsync(s_vsync),
    .active(s_active), .frame_start(s_frame_start)
  );

  hdmi_video_sequencer u_d (
    .clk_pixel(clk), .rst(rst), .en(en_d),
    .busy(d_busy), .req_valid(d_req_valid),
    .req_x(d_req_x), .req_y(d_req_y),
    .hsync(d_hsync), .vsync(d_vsync),
    .active(d_active), .frame_start(d_frame_start)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 run, 2 drain; pos = x + y*HT.
  int          m_mode;
  int          m_pos;
  int          m_cyc;
  logic        m_rv;
  logic [11:0] m_rx, m_ry;
  logic [3:0]  m_hist [8];
  int          mx, my;
  logic        d_vis, d_hs, d_vs, d_fs;

  always_comb begin
    mx    = m_pos % HT;
    my    = m_pos / HT;
    d_vis = (m_mode != 0) && (mx < HA) && (my < VA);
    d_hs  = (m_mode != 0) && (mx >= HSB) && (mx < HSE);
    d_vs  = (m_mode != 0) && (my >= VSB) && (my < VSE);
    d_fs  = (m_mode != 0) && (m_pos == 0);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_pos  <= 0;
      m_cyc  <= 0;
      m_rv   <= 1'b0;
      m_rx   <= 12'd0;
      m_ry   <= 12'd0;
      for (int i = 0; i < 8; i++) m_hist[i] <= 4'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_hist[3'(m_cyc)] <= {d_vis, d_hs, d_vs, d_fs};
      m_rv <= d_vis;
      m_rx <= d_vis ? 12'(mx) : 12'd0;
      m_ry <= d_vis ? 12'(my) : 12'd0;
      case (m_mode)
        0: if (en_s) begin
          m_mode <= 1;
          m_pos  <= 0;
        end
        1: begin
          m_pos <= (m_pos + 1) % TOT;
          if (!en_s) m_mode <= (m_pos == TOT - 1) ? 0 : 2;
        end
        default: begin
          m_pos <= (m_pos + 1) % TOT;
          if (m_pos == TOT - 1) m_mode <= 0;
        end
      endcase
    end
  end

  logic [3:0]  m_e;
  logic [29:0] s_exp;
  logic [29:0] s_obs;
  logic [29:0] d_obs;

  assign m_e   = m_hist[3'(m_cyc - 1 - SL)];
  assign s_exp = {m_mode != 0, m_rv, m_rx, m_ry,
                  ~m_e[2], ~m_e[1], m_e[3], m_e[0]};
  assign s_obs = {s_busy, s_req_valid, s_req_x, s_req_y,
                  s_hsync, s_vsync, s_active, s_frame_start};
  assign d_obs = {d_busy, d_req_valid, d_req_x, d_req_y,
                  d_hsync, d_vsync, d_active, d_frame_start};

  task automatic test_reset();
    logic [29:0] de;
    rst  = 1'b1;
    en_s = 1'b1;
    en_d = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (s_obs !== RST_VEC) begin
      failures++;
      $display("FAIL reset_small obs=%h exp=%h", s_obs, RST_VEC);
    end
    checks++;
    if (d_obs !== RST_VEC) begin
      failures++;
      $display("FAIL reset_default obs=%h exp=%h", d_obs, RST_VEC);
    end
    rst = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      de = {1'b1, k >= 1, (k >= 1) ? 12'(k - 1) : 12'd0, 12'd0,
            1'b1, 1'b1, k >= 3, k == 3};
      checks++;
      if (d_obs !== de) begin
        failures++;
        $display("FAIL startup_default k=%0d obs=%h exp=%h", k, d_obs, de);
      end
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL startup_small k=%0d obs=%h exp=%h", k, s_obs, s_exp);
      end
    end
  endtask

  task automatic test_default_line();
    for (int k = 6; k <= 801; k++) begin
      @(negedge clk);
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL line_small t=%0t obs=%h exp=%h", $time, s_obs, s_exp);
      end
      if (k == 658 || k == 659) begin
        checks++;
        if (d_hsync !== (k == 658)) begin
          failures++;
          $display("FAIL hsync_edge k=%0d obs=%b exp=%b", k, d_hsync, k == 658);
        end
      end
    end
    checks++;
    if ({d_req_valid, d_req_x, d_req_y} !== {1'b1, 12'd0, 12'd1}) begin
      failures++;
      $display("FAIL line1_req obs=%b/%0d/%0d exp=1/0/1",
               d_req_valid, d_req_x, d_req_y);
    end
    en_d = 1'b0;
  endtask

  task automatic test_small_raster();
    int n, act, hl, vl, rq, px, py;
    bit seen, got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL raster_small t=%0t obs=%h exp=%h", $time, s_obs, s_exp);
      end
      got = s_frame_start;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL fs_timeout obs=0 exp=1");
    end
    n = 0; act = 0; hl = 0; vl = 0; rq = 0;
    px = -1; py = -1; seen = 0;
    do begin
      act += int'(s_active);
      hl  += int'(!s_hsync);
      vl  += int'(!s_vsync);
      rq  += int'(s_req_valid);
      if (s_req_valid && s_req_x == 0 && s_req_y == 0 && px >= 0 && !seen) begin
        seen = 1;
        checks++;
        if (px != 7 || py != 3) begin
          failures++;
          $display("FAIL last_req obs=(%0d,%0d) exp=(7,3)", px, py);
        end
      end
      if (s_req_valid) begin
        px = int'(s_req_x);
        py = int'(s_req_y);
      end
      @(negedge clk);
      n++;
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL raster_small t=%0t obs=%h exp=%h", $time, s_obs, s_exp);
      end
    end while (!s_frame_start && n < 300);
    checks++;
    if (n != 120) begin
      failures++;
      $display("FAIL fs_period obs=%0d exp=120", n);
    end
    checks++;
    if (act != 32 || rq != 32) begin
      failures++;
      $display("FAIL frame_counts obs=act%0d/req%0d exp=32/32", act, rq);
    end
    checks++;
    if (hl != 24 || vl != 30) begin
      failures++;
      $display("FAIL sync_counts obs=hs%0d/vs%0d exp=24/30", hl, vl);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wrap_req obs=none exp=(0,0)");
    end
  endtask

  task automatic test_stop_mid_frame();
    int fall, late, px, py;
    bit idle;
    en_s = 1'b0;
    idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !s_busy;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL drain_timeout obs=busy exp=idle");
    end
    repeat (SL + 2) @(negedge clk);
    en_s = 1'b1;
    @(negedge clk);
    repeat (33) begin
      @(negedge clk);
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL stop_small t=%0t obs=%h exp=%h", $time, s_obs, s_exp);
      end
    end
    en_s = 1'b0;
    fall = 0; late = 0; px = -1; py = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL stop_small t=%0t obs=%h exp=%h", $time, s_obs, s_exp);
      end
      if (!s_busy && fall == 0) fall = i;
      if (fall != 0 && s_req_valid) late++;
      if (s_req_valid) begin
        px = int'(s_req_x);
        py = int'(s_req_y);
      end
      if (i == 8) en_s = 1'b1;
      if (i == 10) en_s = 1'b0;
    end
    checks++;
    if (fall != 87) begin
      failures++;
      $display("FAIL busy_fall obs=%0d exp=87", fall);
    end
    checks++;
    if (px != 7 || py != 3) begin
      failures++;
      $display("FAIL stop_last_req obs=(%0d,%0d) exp=(7,3)", px, py);
    end
    checks++;
    if (late != 0) begin
      failures++;
      $display("FAIL req_after_idle obs=%0d exp=0", late);
    end
  endtask

  task automatic test_reset_mid_line();
    en_s = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (s_obs !== RST_VEC) begin
      failures++;
      $display("FAIL midreset_small obs=%h exp=%h", s_obs, RST_VEC);
    end
    checks++;
    if (d_obs !== RST_VEC) begin
      failures++;
      $display("FAIL midreset_default obs=%h exp=%h", d_obs, RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL restart_small k=%0d obs=%h exp=%h", k, s_obs, s_exp);
      end
      if (k == 1) begin
        checks++;
        if ({s_req_valid, s_req_x, s_req_y} !== {1'b1, 24'd0}) begin
          failures++;
          $display("FAIL restart_req obs=%b/%0d/%0d exp=1/0/0",
                   s_req_valid, s_req_x, s_req_y);
        end
      end
      if (k == 4) begin
        checks++;
        if ({s_active, s_frame_start} !== 2'b11) begin
          failures++;
          $display("FAIL restart_fs obs=%b%b exp=11", s_active, s_frame_start);
        end
      end
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (s_obs !== s_exp) begin
        failures++;
        $display("FAIL random_small t=%0t obs=%h exp=%h", $time, s_obs, s_exp);
      end
      if ($urandom_range(0, 59) == 0) en_s = ~en_s;
    end
  endtask

  initial begin
    rst  = 1'b1;
    en_s = 1'b0;
    en_d = 1'b0;
    test_reset();
    test_default_line();
    test_small_raster();
    test_stop_mid_frame();
    test_reset_mid_line();
    test_random_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
